// File: rtl/rs_issue_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_issue_scheduler_pkg
// Description : Shared types and constants for the reservation-station issue
//               scheduler (row count, tag width, ALU FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package rs_issue_scheduler_pkg;

  localparam int NUM_ROWS_DEFAULT = 6;
  localparam int TAG_W_DEFAULT    = 4;

  // Tag value meaning "no producer"; real tags are row index + 1.
  localparam int NO_PRODUCER_TAG  = 0;

  // Value of the CDB priority bit that favours ALU0.
  localparam logic PRIO_ALU0 = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } alu_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin first-set finder. Scans the mask
//               starting at the given pointer, wrapping from N-1 to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N  = 6,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] index
);

  int            cand;
  logic [IW-1:0] pos;

  // Walk positions start, start+1, ... modulo N and keep the first set bit.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = 0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      cand = int'(start) + i;
      if (cand >= N) cand = cand - N;
      pos = IW'(cand);
      if (!found && mask[pos]) begin
        found = 1'b1;
        index = pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rs_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rs_issue_scheduler
// Description : Issues ready reservation-station rows to two ALUs, tracks each
//               ALU through IDLE/EXEC/WB and arbitrates the common data bus.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_issue_scheduler
  import rs_issue_scheduler_pkg::*;
#(
  parameter int NUM_ROWS = NUM_ROWS_DEFAULT,
  parameter int TAG_W    = TAG_W_DEFAULT
) (
  input  logic                            clk_100mhz,
  input  logic                            sys_rst,
  input  logic [NUM_ROWS-1:0]             row_ready_in,
  output logic [NUM_ROWS-1:0]             issue_grant_out,
  output logic [1:0]                      alu_start_out,
  output logic [2*$clog2(NUM_ROWS)-1:0]   alu_row_out,
  input  logic [1:0]                      alu_done_in,
  input  logic [63:0]                     alu_result_in,
  output logic                            cdb_valid_out,
  output logic [TAG_W-1:0]                cdb_tag_out,
  output logic [31:0]                     cdb_data_out
);

  localparam int IDX_W = $clog2(NUM_ROWS);

  alu_state_t         state_q [2];
  alu_state_t         state_d [2];
  logic [IDX_W-1:0]   rr_ptr;
  logic               prio;
  logic [31:0]        result_q [2];

  logic               first_found;
  logic [IDX_W-1:0]   first_idx;
  logic               second_found;
  logic [IDX_W-1:0]   second_idx;
  logic [NUM_ROWS-1:0] second_mask;
  logic [IDX_W-1:0]   second_start;

  logic [1:0]         grant_valid;
  logic [IDX_W-1:0]   grant_row [2];
  logic [1:0]         in_wb;
  logic [1:0]         cdb_win;

  function automatic logic [IDX_W-1:0] next_row(input logic [IDX_W-1:0] r);
    return (r == IDX_W'(NUM_ROWS - 1)) ? '0 : r + IDX_W'(1);
  endfunction

  // Second search excludes the first winner and continues just past it, so
  // both picks follow round-robin order and can never name the same row.
  always_comb begin
    second_mask            = row_ready_in;
    second_mask[first_idx] = 1'b0;
    second_start           = next_row(first_idx);
  end

  rr_pick #(.N(NUM_ROWS), .IW(IDX_W)) u_pick_first (
    .mask  (row_ready_in),
    .start (rr_ptr),
    .found (first_found),
    .index (first_idx)
  );

  rr_pick #(.N(NUM_ROWS), .IW(IDX_W)) u_pick_second (
    .mask  (second_mask),
    .start (second_start),
    .found (second_found),
    .index (second_idx)
  );

  // Grant selection: first ready row to ALU0 if idle, else ALU1; second row
  // to ALU1 only when both are idle. Suppressed while reset is held.
  always_comb begin
    grant_valid     = 2'b00;
    grant_row[0]    = '0;
    grant_row[1]    = '0;
    issue_grant_out = '0;
    if (!sys_rst && first_found) begin
      if (state_q[0] == ST_IDLE) begin
        grant_valid[0] = 1'b1;
        grant_row[0]   = first_idx;
        if (state_q[1] == ST_IDLE && second_found) begin
          grant_valid[1] = 1'b1;
          grant_row[1]   = second_idx;
        end
      end else if (state_q[1] == ST_IDLE) begin
        grant_valid[1] = 1'b1;
        grant_row[1]   = first_idx;
      end
    end
    if (grant_valid[0]) issue_grant_out[grant_row[0]] = 1'b1;
    if (grant_valid[1]) issue_grant_out[grant_row[1]] = 1'b1;
  end

  // CDB arbitration: a lone WB ALU wins; on a collision the prio bit decides.
  always_comb begin
    in_wb[0] = (state_q[0] == ST_WB);
    in_wb[1] = (state_q[1] == ST_WB);
    if (&in_wb) cdb_win = (prio == PRIO_ALU0) ? 2'b01 : 2'b10;
    else        cdb_win = in_wb;
  end

  // Per-ALU next-state logic; done strobes only matter in EXEC.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        ST_IDLE: if (grant_valid[k]) state_d[k] = ST_EXEC;
        ST_EXEC: if (alu_done_in[k]) state_d[k] = ST_WB;
        ST_WB:   if (cdb_win[k])     state_d[k] = ST_IDLE;
        default: state_d[k] = ST_IDLE;
      endcase
    end
  end

  // FSM state registers.
  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      state_q[0] <= ST_IDLE;
      state_q[1] <= ST_IDLE;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
    end
  end

  // Datapath: start pulses, row/result capture, round-robin pointer, CDB.
  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      alu_start_out <= 2'b00;
      alu_row_out   <= '0;
      result_q[0]   <= '0;
      result_q[1]   <= '0;
      rr_ptr        <= '0;
      prio          <= PRIO_ALU0;
      cdb_valid_out <= 1'b0;
      cdb_tag_out   <= TAG_W'(NO_PRODUCER_TAG);
      cdb_data_out  <= '0;
    end else begin
      alu_start_out <= grant_valid;
      for (int k = 0; k < 2; k++) begin
        if (grant_valid[k]) alu_row_out[k*IDX_W +: IDX_W] <= grant_row[k];
        if (state_q[k] == ST_EXEC && alu_done_in[k])
          result_q[k] <= alu_result_in[k*32 +: 32];
      end
      // ALU1's row is always the later one in scan order when both issue.
      if (|grant_valid)
        rr_ptr <= next_row(grant_valid[1] ? grant_row[1] : grant_row[0]);
      cdb_valid_out <= |cdb_win;
      // After each broadcast, priority passes to the other ALU.
      if (cdb_win[0]) begin
        cdb_tag_out  <= TAG_W'(alu_row_out[0 +: IDX_W]) + TAG_W'(1);
        cdb_data_out <= result_q[0];
        prio         <= ~PRIO_ALU0;
      end else if (cdb_win[1]) begin
        cdb_tag_out  <= TAG_W'(alu_row_out[IDX_W +: IDX_W]) + TAG_W'(1);
        cdb_data_out <= result_q[1];
        prio         <= PRIO_ALU0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rs_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_issue_scheduler
// Description : Directed self-checking bench for rs_issue_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_issue_scheduler;

  logic        clk_100mhz = 1'b0;
  logic        sys_rst;
  logic [5:0]  row_ready_in;
  logic [5:0]  issue_grant_out;
  logic [1:0]  alu_start_out;
  logic [5:0]  alu_row_out;
  logic [1:0]  alu_done_in;
  logic [63:0] alu_result_in;
  logic        cdb_valid_out;
  logic [3:0]  cdb_tag_out;
  logic [31:0] cdb_data_out;

  int n_cmp = 0;
  int n_bad = 0;

  rs_issue_scheduler #(.NUM_ROWS(6), .TAG_W(4)) dut (
    .clk_100mhz      (clk_100mhz),
    .sys_rst         (sys_rst),
    .row_ready_in    (row_ready_in),
    .issue_grant_out (issue_grant_out),
    .alu_start_out   (alu_start_out),
    .alu_row_out     (alu_row_out),
    .alu_done_in     (alu_done_in),
    .alu_result_in   (alu_result_in),
    .cdb_valid_out   (cdb_valid_out),
    .cdb_tag_out     (cdb_tag_out),
    .cdb_data_out    (cdb_data_out)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled at the negedge.
  task automatic tick();
    @(posedge clk_100mhz);
    @(negedge clk_100mhz);
  endtask

  task automatic chk_cdb(input string tag, input logic v, input logic [3:0] t, input logic [31:0] d);
    chk({tag, "_valid"}, 64'(cdb_valid_out), 64'(v));
    chk({tag, "_tag"},   64'(cdb_tag_out),   64'(t));
    chk({tag, "_data"},  64'(cdb_data_out),  64'(d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_rst       = 1'b1;
    row_ready_in  = 6'b111111;
    alu_done_in   = 2'b00;
    alu_result_in = '0;
    tick();
    #1;
    chk("rst_grant", 64'(issue_grant_out), 64'h0);
    chk("rst_start", 64'(alu_start_out), 64'h0);
    chk("rst_row", 64'(alu_row_out), 64'h0);
    chk_cdb("rst_cdb", 1'b0, 4'd0, 32'd0);

    // Single row: grant in the first cycle after reset, broadcast 3 cycles later.
    @(negedge clk_100mhz);
    sys_rst      = 1'b0;
    row_ready_in = 6'b000100;
    #1 chk("t1_grant", 64'(issue_grant_out), 64'h04);
    tick();
    row_ready_in = 6'b000000;
    chk("t1_start", 64'(alu_start_out), 64'h1);
    chk("t1_row0", 64'(alu_row_out[2:0]), 64'd2);
    alu_done_in   = 2'b01;
    alu_result_in = {32'd0, 32'd42};
    tick();
    alu_done_in = 2'b00;
    chk("t1_start_pulse", 64'(alu_start_out), 64'h0);
    chk("t1_no_early_cdb", 64'(cdb_valid_out), 64'h0);
    tick();
    chk_cdb("t1_cdb", 1'b1, 4'd3, 32'd42);
    tick();
    chk_cdb("t1_cdb_hold", 1'b0, 4'd3, 32'd42);

    // Dual issue from rr_ptr=0.
    sys_rst = 1'b1;
    tick();
    sys_rst      = 1'b0;
    row_ready_in = 6'b010010;
    #1 chk("t2_grant", 64'(issue_grant_out), 64'h12);
    tick();
    row_ready_in = 6'b000000;
    chk("t2_start", 64'(alu_start_out), 64'h3);
    chk("t2_rows", 64'(alu_row_out), 64'({3'd4, 3'd1}));
    // Both ALUs busy: nothing may be granted.
    row_ready_in = 6'b111111;
    #1 chk("t6_busy_grant", 64'(issue_grant_out), 64'h0);
    row_ready_in  = 6'b000000;
    alu_done_in   = 2'b11;
    alu_result_in = {32'd200, 32'd100};
    tick();
    // Both in WB: done strobes must be ignored.
    alu_done_in   = 2'b11;
    alu_result_in = {32'd999, 32'd999};
    chk("t3_no_cdb_yet", 64'(cdb_valid_out), 64'h0);
    tick();
    alu_done_in = 2'b00;
    chk_cdb("t3_cdb_alu0", 1'b1, 4'd2, 32'd100);
    tick();
    chk_cdb("t3_cdb_alu1", 1'b1, 4'd5, 32'd200);
    tick();
    chk("t3_cdb_idle", 64'(cdb_valid_out), 64'h0);

    // Second collision: prio must be back at ALU0; rr_ptr=5 -> rows 1,2.
    row_ready_in = 6'b000110;
    #1 chk("t3b_grant", 64'(issue_grant_out), 64'h06);
    tick();
    row_ready_in  = 6'b000000;
    alu_done_in   = 2'b11;
    alu_result_in = {32'd8, 32'd7};
    tick();
    alu_done_in = 2'b00;
    tick();
    chk_cdb("t3b_cdb_first", 1'b1, 4'd2, 32'd7);
    tick();
    chk_cdb("t3b_cdb_second", 1'b1, 4'd3, 32'd8);

    // Wrap: build rr_ptr=5 with ALU1 busy and ALU0 idle.
    sys_rst = 1'b1;
    tick();
    sys_rst      = 1'b0;
    row_ready_in = 6'b001000;
    #1 chk("t4_grant_a", 64'(issue_grant_out), 64'h08);
    tick();
    row_ready_in  = 6'b010000;
    alu_done_in   = 2'b01;
    alu_result_in = {32'd0, 32'd11};
    #1 chk("t4_grant_b", 64'(issue_grant_out), 64'h10);
    tick();
    row_ready_in = 6'b000000;
    alu_done_in  = 2'b00;
    chk("t4_start_b", 64'(alu_start_out), 64'h2);
    chk("t4_row1", 64'(alu_row_out[5:3]), 64'd4);
    tick();
    chk_cdb("t4_cdb", 1'b1, 4'd4, 32'd11);
    row_ready_in = 6'b100001;
    #1 chk("t4_wrap_grant", 64'(issue_grant_out), 64'h20);
    tick();
    chk("t4_start_c", 64'(alu_start_out), 64'h1);
    chk("t4_row0", 64'(alu_row_out[2:0]), 64'd5);
    row_ready_in  = 6'b111111;
    alu_done_in   = 2'b10;
    alu_result_in = {32'hFFFF_FFF9, 32'd0};
    #1 chk("t6_busy_grant2", 64'(issue_grant_out), 64'h0);
    tick();
    alu_done_in = 2'b00;
    #1 chk("t6_wb_no_grant", 64'(issue_grant_out), 64'h0);
    @(negedge clk_100mhz);
    chk_cdb("t4_cdb_neg", 1'b1, 4'd5, 32'hFFFF_FFF9);
    #1 chk("t4_regrant_ptr0", 64'(issue_grant_out), 64'h01);
    tick();
    row_ready_in  = 6'b000000;
    alu_done_in   = 2'b10;
    alu_result_in = {32'hFFFF_FFF9, 32'd0};
    tick();
    alu_done_in = 2'b00;

    // Reset while ALU1 is in WB holding -7: no broadcast may escape.
    sys_rst = 1'b1;
    #1;
    chk("t5_rst_start", 64'(alu_start_out), 64'h0);
    chk("t5_rst_row", 64'(alu_row_out), 64'h0);
    chk_cdb("t5_rst_cdb", 1'b0, 4'd0, 32'd0);
    tick();
    sys_rst = 1'b0;
    tick();
    chk("t5_no_cdb_after", 64'(cdb_valid_out), 64'h0);
    row_ready_in = 6'b000011;
    #1 chk("t5_both_idle_ptr0", 64'(issue_grant_out), 64'h03);
    tick();
    row_ready_in = 6'b000000;
    chk("t5_start", 64'(alu_start_out), 64'h3);
    chk("t5_no_cdb_end", 64'(cdb_valid_out), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
